// File: rtl/axis_cnt_gen_pkg.sv
// Shared types and default widths for the AXI-Stream counting frame generator.
package axis_cnt_gen_pkg;

   // Default widths: tdata, frame length / beat counter, gap length, frame counter.
   localparam int unsigned DSIZE_DEF = 8;
   localparam int unsigned LSIZE_DEF = 16;
   localparam int unsigned GSIZE_DEF = 8;
   localparam int unsigned CSIZE     = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StGap  = 2'd2
   } state_e;

endpackage

// File: rtl/axis_cnt_gen_if.sv
// AXI-Stream master/slave bundle carrying tdata, tvalid, tready and tlast.
interface axis_cnt_gen_if
   import axis_cnt_gen_pkg::*;
#(
   parameter int unsigned DSIZE = DSIZE_DEF
);

   logic [DSIZE-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/axis_cnt_gen.sv
// Frame generator: emits frames of incrementing-count beats on an AXI-Stream
// master, separated by a programmable number of idle cycles. All outputs are
// registered, so tvalid never depends combinationally on tready.
module axis_cnt_gen
   import axis_cnt_gen_pkg::*;
#(
   parameter int unsigned DSIZE = DSIZE_DEF,
   parameter int unsigned LSIZE = LSIZE_DEF,
   parameter int unsigned GSIZE = GSIZE_DEF
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [LSIZE-1:0]  frame_len,
   input  logic [GSIZE-1:0]  gap_len,
   axis_cnt_gen_if.master    m_axis,
   output logic [CSIZE-1:0]  frame_cnt,
   output logic              busy
);

   state_e            state_q, state_d;
   logic              armed_q, armed_d;
   logic [LSIZE-1:0]  len_q, len_d;
   logic [LSIZE-1:0]  beat_q, beat_d;
   logic [GSIZE-1:0]  gap_q, gap_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;
   logic [DSIZE-1:0]  tdata_q, tdata_d;
   logic [CSIZE-1:0]  cnt_q, cnt_d;
   logic              busy_q;

   logic [LSIZE-1:0]  eff_len;
   logic [LSIZE-1:0]  beat_nxt;
   logic              xfer;
   logic              start;
   logic              stop;

   // A zero frame length still produces a single-beat frame.
   assign eff_len  = (frame_len == '0) ? LSIZE'(1) : frame_len;
   assign beat_nxt = beat_q + LSIZE'(1);
   assign xfer     = tvalid_q & m_axis.tready;

   // Next-state logic: FSM transitions, beat/gap counters and output registers.
   always_comb begin
      state_d  = state_q;
      armed_d  = 1'b1;
      len_d    = len_q;
      beat_d   = beat_q;
      gap_d    = gap_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tdata_d  = tdata_q;
      cnt_d    = cnt_q;
      start    = 1'b0;
      stop     = 1'b0;

      unique case (state_q)
         StIdle: begin
            // armed_q holds off the first frame for one edge after reset release.
            if (enable && armed_q) begin
               start = 1'b1;
            end
         end
         StSend: begin
            if (xfer) begin
               if (tlast_q) begin
                  cnt_d = cnt_q + CSIZE'(1);
                  if (gap_len != '0) begin
                     state_d  = StGap;
                     gap_d    = gap_len;
                     tvalid_d = 1'b0;
                     tlast_d  = 1'b0;
                  end else if (enable) begin
                     start = 1'b1;
                  end else begin
                     stop = 1'b1;
                  end
               end else begin
                  beat_d  = beat_nxt;
                  tdata_d = DSIZE'(beat_nxt);
                  tlast_d = (beat_nxt == len_q - LSIZE'(1));
               end
            end
         end
         StGap: begin
            // gap_q is loaded non-zero, so the last idle cycle is when it reads 1.
            if (gap_q == GSIZE'(1)) begin
               if (enable) begin
                  start = 1'b1;
               end else begin
                  stop = 1'b1;
               end
            end else begin
               gap_d = gap_q - GSIZE'(1);
            end
         end
         default: begin
            stop = 1'b1;
         end
      endcase

      if (start) begin
         state_d  = StSend;
         len_d    = eff_len;
         beat_d   = '0;
         tdata_d  = '0;
         tvalid_d = 1'b1;
         tlast_d  = (eff_len == LSIZE'(1));
      end

      if (stop) begin
         state_d  = StIdle;
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         armed_q  <= 1'b0;
         len_q    <= '0;
         beat_q   <= '0;
         gap_q    <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         armed_q  <= armed_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         gap_q    <= gap_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
         cnt_q    <= cnt_d;
         busy_q   <= (state_d != StIdle);
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign frame_cnt     = cnt_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_axis_cnt_gen.sv
// Scoreboard bench for axis_cnt_gen: expected beats are queued as frames are
// requested and popped as the DUT transfers them.
module tb_axis_cnt_gen;
   import axis_cnt_gen_pkg::*;

   localparam int unsigned DSIZE = 8;
   localparam int unsigned LSIZE = 16;
   localparam int unsigned GSIZE = 8;
   localparam int          BUDGET = 20000;

   typedef struct packed {
      logic [DSIZE-1:0] data;
      logic             last;
   } beat_t;

   logic              clock = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic [LSIZE-1:0]  frame_len = '0;
   logic [GSIZE-1:0]  gap_len = '0;
   logic [15:0]       frame_cnt;
   logic              busy;

   axis_cnt_gen_if #(.DSIZE(DSIZE)) m_axis ();

   axis_cnt_gen #(
      .DSIZE (DSIZE),
      .LSIZE (LSIZE),
      .GSIZE (GSIZE)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .enable    (enable),
      .frame_len (frame_len),
      .gap_len   (gap_len),
      .m_axis    (m_axis),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   beat_t       exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          tlast_seen = 0;
   int          beats_seen = 0;
   int          gap_seen = -1;
   int          rdy_mode = 0;
   logic [15:0] exp_frames = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_frame(input int len);
      int n;
      beat_t b;
      n = (len == 0) ? 1 : len;
      for (int i = 0; i < n; i++) begin
         b.data = DSIZE'(i);
         b.last = (i == n - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic wait_idle(input string tag);
      int budget;
      budget = 0;
      while ((busy || m_axis.tvalid) && budget < BUDGET) begin
         tick();
         budget++;
      end
      if (budget >= BUDGET) check_eq({tag, "_idle_timeout"}, 32'd0, 32'd1);
      check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   // Requests n frames, dropping enable once the last one has started.
   task automatic run_frames(input int n, input int len, input int gap, input string tag);
      int base;
      int budget;
      base = tlast_seen;
      frame_len = LSIZE'(len);
      gap_len = GSIZE'(gap);
      for (int k = 0; k < n; k++) push_frame(len);
      enable = 1'b1;
      budget = 0;
      while (!(tlast_seen >= base + n - 1 && m_axis.tvalid) && budget < BUDGET) begin
         tick();
         budget++;
      end
      enable = 1'b0;
      if (budget >= BUDGET) check_eq({tag, "_start_timeout"}, 32'd0, 32'd1);
      wait_idle(tag);
      check_eq({tag, "_frames"}, 32'(tlast_seen - base), 32'(n));
      check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Sink ready pattern: 0 always ready, 1 toggle, 2 random, 3 never ready.
   initial begin
      m_axis.tready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (rdy_mode)
            1:       m_axis.tready = ~m_axis.tready;
            2:       m_axis.tready = 1'($urandom_range(0, 1));
            3:       m_axis.tready = 1'b0;
            default: m_axis.tready = 1'b1;
         endcase
      end
   end

   // Monitor: scoreboard pops, hold-while-stalled, frame counter and gap length.
   initial begin
      beat_t      e;
      logic       prev_stall;
      logic [7:0] prev_data;
      logic       prev_last;
      logic       after_last;
      int         idle_run;
      prev_stall = 1'b0;
      prev_data = '0;
      prev_last = 1'b0;
      after_last = 1'b0;
      idle_run = 0;
      forever begin
         @(negedge clock);
         if (rst_n) begin
            check_eq("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
            if (prev_stall) begin
               check_eq("hold_valid", 32'(m_axis.tvalid), 32'd1);
               check_eq("hold_data", 32'(m_axis.tdata), 32'(prev_data));
               check_eq("hold_last", 32'(m_axis.tlast), 32'(prev_last));
            end
            if (m_axis.tvalid) begin
               if (after_last) begin
                  gap_seen = idle_run;
                  after_last = 1'b0;
               end
               if (m_axis.tready) begin
                  if (exp_q.size() == 0) begin
                     check_eq("unexpected_beat", 32'd1, 32'd0);
                  end else begin
                     e = exp_q.pop_front();
                     check_eq("beat_data", 32'(m_axis.tdata), 32'(e.data));
                     check_eq("beat_last", 32'(m_axis.tlast), 32'(e.last));
                  end
                  beats_seen++;
                  if (m_axis.tlast) begin
                     exp_frames = exp_frames + 16'd1;
                     tlast_seen++;
                     after_last = 1'b1;
                     idle_run = 0;
                  end
               end
            end else begin
               idle_run++;
            end
            prev_stall = m_axis.tvalid && !m_axis.tready;
            prev_data = m_axis.tdata;
            prev_last = m_axis.tlast;
         end else begin
            prev_stall = 1'b0;
            after_last = 1'b0;
            idle_run = 0;
            exp_frames = '0;
            exp_q.delete();
         end
      end
   end

   initial begin
      int base;
      int budget;

      // Reset values, with enable already requesting a frame.
      enable = 1'b1;
      frame_len = LSIZE'(2);
      gap_len = '0;
      #2;
      check_eq("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
      check_eq("rst_tlast", 32'(m_axis.tlast), 32'd0);
      check_eq("rst_tdata", 32'(m_axis.tdata), 32'd0);
      check_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      check_eq("rst_hold_tvalid", 32'(m_axis.tvalid), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      check_eq("first_edge_tvalid", 32'(m_axis.tvalid), 32'd0);
      run_frames(1, 2, 0, "post_reset");

      // Two frames of 4 with a 2-cycle gap.
      rdy_mode = 0;
      gap_seen = -1;
      run_frames(2, 4, 2, "len4_gap2");
      check_eq("len4_gap2_idle", 32'(gap_seen), 32'd2);

      // Toggling ready: 3 beats held while stalled, exactly 3 transfers.
      rdy_mode = 1;
      base = beats_seen;
      run_frames(1, 3, 0, "len3_toggle");
      check_eq("len3_toggle_beats", 32'(beats_seen - base), 32'd3);

      // Long frame: data wraps at 256, tlast on beat 299.
      rdy_mode = 2;
      run_frames(1, 300, 1, "len300");

      // Ready held low for a long stretch.
      rdy_mode = 3;
      frame_len = LSIZE'(3);
      gap_len = '0;
      push_frame(3);
      enable = 1'b1;
      budget = 0;
      while (!m_axis.tvalid && budget < BUDGET) begin
         tick();
         budget++;
      end
      enable = 1'b0;
      repeat (50) tick();
      check_eq("stall_tvalid", 32'(m_axis.tvalid), 32'd1);
      check_eq("stall_tdata", 32'(m_axis.tdata), 32'd0);
      rdy_mode = 0;
      wait_idle("stall");
      check_eq("stall_queue_empty", 32'(exp_q.size()), 32'd0);

      // Enable dropped after beat 1: frame of 5 still completes, then idle.
      base = tlast_seen;
      frame_len = LSIZE'(5);
      gap_len = GSIZE'(3);
      push_frame(5);
      enable = 1'b1;
      budget = 0;
      while (beats_seen < 2 + (beats_seen - beats_seen) && budget < BUDGET) begin
         tick();
         budget++;
      end
      budget = 0;
      begin
         int b0;
         b0 = beats_seen;
         while (beats_seen < b0 + 2 && budget < BUDGET) begin
            tick();
            budget++;
         end
      end
      enable = 1'b0;
      wait_idle("drop_en");
      check_eq("drop_en_frames", 32'(tlast_seen - base), 32'd1);
      check_eq("drop_en_queue_empty", 32'(exp_q.size()), 32'd0);

      // Zero length and zero gap: back-to-back one-beat frames.
      gap_seen = -1;
      run_frames(4, 0, 0, "len0_gap0");
      check_eq("len0_gap0_idle", 32'(gap_seen), 32'd0);

      // Reset mid-frame at beat 2 of 6.
      frame_len = LSIZE'(6);
      gap_len = '0;
      push_frame(6);
      enable = 1'b1;
      budget = 0;
      while (!(m_axis.tvalid && m_axis.tdata == 8'd2) && budget < BUDGET) begin
         tick();
         budget++;
      end
      if (budget >= BUDGET) check_eq("midrst_timeout", 32'd0, 32'd1);
      #1;
      rst_n = 1'b0;
      enable = 1'b0;
      #1;
      check_eq("midrst_tvalid", 32'(m_axis.tvalid), 32'd0);
      check_eq("midrst_tlast", 32'(m_axis.tlast), 32'd0);
      check_eq("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      #1;
      rst_n = 1'b1;
      tick();
      run_frames(1, 6, 0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/axis_cnt_gen.md
AXIS_CNT_GEN -- requirements
Module: axis_cnt_gen

Interface
REQ-001 SHALL have parameter DSIZE, default 8, tdata width in bits.
REQ-002 SHALL have parameter LSIZE, default 16, width of frame_len and beat counter.
REQ-003 SHALL have parameter GSIZE, default 8, width of gap_len.
REQ-004 clock  input  1  clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  generation request; level sensitive.
REQ-007 frame_len  input  LSIZE  beats per frame; sampled at frame start.
REQ-008 gap_len  input  GSIZE  idle cycles between frames; sampled at frame end.
REQ-009 m_tdata  output  DSIZE  stream data.
REQ-010 m_tvalid  output  1  stream valid.
REQ-011 m_tready  input  1  stream ready from sink.
REQ-012 m_tlast  output  1  last beat of frame.
REQ-013 frame_cnt  output  16  count of completed frames.
REQ-014 busy  output  1  high when state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, GAP.
REQ-016 IDLE -> SEND when enable=1; first m_tvalid=1 on the next cycle.
REQ-017 On entering SEND, SHALL latch frame_len; frame_len=0 SHALL be treated as 1.
REQ-018 A beat transfers only on a cycle where m_tvalid=1 and m_tready=1.
REQ-019 Once m_tvalid=1, m_tvalid, m_tdata and m_tlast SHALL hold until the transfer; no retraction.
REQ-020 m_tdata SHALL equal the low DSIZE bits of the 0-based beat index in the frame, wrapping modulo 2^DSIZE.
REQ-021 m_tlast SHALL be 1 exactly on beat index latched_len-1.
REQ-022 On the tlast transfer, frame_cnt SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-023 After the tlast transfer: if gap_len>0 go GAP with m_tvalid=0 for exactly gap_len cycles; if gap_len=0 and enable=1 go SEND with the next frame's beat 0 valid on the following cycle; if enable=0 go IDLE.
REQ-024 GAP exit after gap_len cycles: SEND if enable=1, else IDLE.
REQ-025 enable falling during SEND SHALL NOT truncate the frame; the frame completes, then IDLE.
REQ-026 enable falling during GAP SHALL cause IDLE at GAP end.
REQ-027 Changes to frame_len/gap_len mid-frame SHALL NOT affect the current frame.
REQ-028 m_tready may be held 0 indefinitely; SHALL stall with no beat loss or duplication.
REQ-029 m_tvalid SHALL NOT depend combinationally on m_tready; all outputs registered.

Reset
REQ-030 On rst_n=0: state IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, frame_cnt=0, busy=0, counters 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; no tlast is emitted for it.
REQ-032 After rst_n release, first m_tvalid no earlier than the second rising edge.

Structure
REQ-033 FSM state enum and default-width constants SHALL reside in package axis_cnt_gen_pkg.
REQ-034 No sub-module; beat counter, gap counter and FSM in one module.

Verification
REQ-035 frame_len=4, gap_len=2, enable=1, m_tready=1 -> data 0,1,2,3, tlast on 3, 2 idle cycles, repeats; frame_cnt 1 after first frame.
REQ-036 frame_len=3, m_tready toggling 1,0,1,0 -> data 0,1,2 each held stable while stalled; exactly 3 transfers.
REQ-037 frame_len=300, DSIZE=8 -> beat 255 data 0xFF, beat 256 data 0x00, tlast on beat 299.
REQ-038 frame_len=5, enable dropped after beat 1 -> beats 2..4 still sent, tlast on 4, then IDLE, busy=0.
REQ-039 frame_len=0, gap_len=0 -> one-beat frames back-to-back, tlast=1 every beat, frame_cnt +1 per beat.
REQ-040 rst_n pulsed low at beat 2 of frame_len=6 -> m_tvalid=0 immediately, frame_cnt=0; next frame restarts at data 0.
